// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the two-requester RAM arbiter/controller.
package ram_ctrl_pkg;

    localparam int DATA_W_DFLT = 8;
    localparam int ADDR_W_DFLT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to ptr_i.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arb_ctrl.sv
// Arbitrates two requesters onto a single-port RAM: IDLE -> ACCESS -> DONE,
// one transaction at a time, with a round-robin pointer for ties.
module ram_arb_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic              CLK_,
    input  logic              CLR,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              ram_r_w,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          arb_gnt;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    rr_arb2 u_arb (
        .req_i ({req1, req0}),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                gnt_d = 2'b00;
                if (arb_gnt != 2'b00) begin
                    gnt_d   = arb_gnt;
                    // Pointer moves to whoever did not win this grant.
                    ptr_d   = arb_gnt[0];
                    rw_d    = arb_gnt[1] ? rw1    : rw0;
                    addr_d  = arb_gnt[1] ? addr1  : addr0;
                    wdata_d = arb_gnt[1] ? wdata1 : wdata0;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = DONE;
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                if (rw_q) begin
                    rdata_d = ram_dout;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge CLK_ or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            gnt_q   <= 2'b00;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Write strobe decodes straight from state so reset drops it without waiting for a clock.
    assign ram_r_w  = !((state_q == ACCESS) && !rw_q);
    assign ram_addr = addr_q;
    assign ram_din  = wdata_q;
    assign rdata    = rdata_q;
    assign gnt      = gnt_q;
    assign busy     = (state_q != IDLE);
    assign ack0     = (state_q == DONE) && gnt_q[0];
    assign ack1     = (state_q == DONE) && gnt_q[1];

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Bench for ram_arb_ctrl: vector table, directed corner sequences and a
// randomized run scored against a transaction-level timing model.
module tb_ram_arb_ctrl;

    logic       CLK_ = 1'b0;
    logic       CLR  = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, rw0 = 1'b1, rw1 = 1'b1;
    logic [0:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, busy, ram_r_w;
    logic [7:0] rdata, ram_din, ram_dout;
    logic [1:0] gnt;
    logic [0:0] ram_addr;

    logic [7:0] ram [0:1] = '{8'h00, 8'h00};

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK_ = ~CLK_;

    always @(posedge CLK_) if (!ram_r_w) ram[ram_addr] <= ram_din;
    assign ram_dout = ram[ram_addr];

    ram_arb_ctrl #(.DATA_W(8), .ADDR_W(1)) dut (
        .CLK_(CLK_), .CLR(CLR),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .gnt(gnt), .busy(busy),
        .ram_r_w(ram_r_w), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    typedef struct {
        logic       r0, r1, w0, w1;
        logic [0:0] a0, a1;
        logic [7:0] d0, d1;
        logic [1:0] e_gnt, e_ack;
        logic       e_rw, e_busy;
        logic [7:0] e_rd, e_din;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_reqs();
        req0 = 1'b0; req1 = 1'b0; rw0 = 1'b1; rw1 = 1'b1;
    endtask

    task automatic do_reset();
        clear_reqs();
        CLR = 1'b0;
        repeat (2) @(posedge CLK_);
        #1;
        chk("rst_gnt", {30'd0, gnt}, 0);
        chk("rst_ack", {30'd0, ack1, ack0}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rw", {31'd0, ram_r_w}, 1);
        chk("rst_rdata", {24'd0, rdata}, 0);
        chk("rst_addr", {31'd0, ram_addr}, 0);
        chk("rst_din", {24'd0, ram_din}, 0);
        CLR = 1'b1;
    endtask

    task automatic do_txn(input int who, input logic rw, input logic [0:0] a, input logic [7:0] d);
        bit got = 0;
        if (who == 0) begin req0 = 1; rw0 = rw; addr0 = a; wdata0 = d; end
        else          begin req1 = 1; rw1 = rw; addr1 = a; wdata1 = d; end
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge CLK_); #1;
            if ((who == 0) ? ack0 : ack1) got = 1;
        end
        chk("txn_ack", {31'd0, got}, 1);
        clear_reqs();
        @(posedge CLK_); #1;
    endtask

    initial begin
        vec_t       vecs [6];
        int         ack_cyc [$];
        int         ack_own [$];
        logic [7:0] keep;
        logic       p [2];
        logic       q_rw [2];
        logic [0:0] q_a [2];
        logic [7:0] q_d [2];
        int         m_start, m_own, ph;
        logic       m_ptr, m_rw;
        logic [0:0] m_a;
        logic [7:0] m_d, m_rdata;
        logic [7:0] m_mem [2];
        logic [1:0] oh;

        vecs[0] = '{1,0,0,1, 0,0, 8'hA5,8'h00, 2'b01,2'b00,0,1, 8'h00,8'hA5};
        vecs[1] = '{1,0,0,1, 0,0, 8'hA5,8'h00, 2'b01,2'b01,1,1, 8'h00,8'hA5};
        vecs[2] = '{0,1,1,1, 0,0, 8'h00,8'h00, 2'b00,2'b00,1,0, 8'h00,8'hA5};
        vecs[3] = '{0,1,1,1, 0,0, 8'h00,8'h00, 2'b10,2'b00,1,1, 8'h00,8'h00};
        vecs[4] = '{0,1,1,1, 0,0, 8'h00,8'h00, 2'b10,2'b10,1,1, 8'h00,8'h00};
        vecs[5] = '{0,0,1,1, 0,0, 8'h00,8'h00, 2'b00,2'b00,1,0, 8'hA5,8'h00};

        // Write A5 by requester 0, then read it back through requester 1.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1; rw0 = vecs[i].w0; rw1 = vecs[i].w1;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1; wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
            @(posedge CLK_); #1;
            chk($sformatf("v%0d_gnt", i), {30'd0, gnt}, {30'd0, vecs[i].e_gnt});
            chk($sformatf("v%0d_ack", i), {30'd0, ack1, ack0}, {30'd0, vecs[i].e_ack});
            chk($sformatf("v%0d_rw", i), {31'd0, ram_r_w}, {31'd0, vecs[i].e_rw});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
            chk($sformatf("v%0d_rdata", i), {24'd0, rdata}, {24'd0, vecs[i].e_rd});
            chk($sformatf("v%0d_din", i), {24'd0, ram_din}, {24'd0, vecs[i].e_din});
        end

        // Both requesters held: alternating grants, acks three cycles apart.
        do_reset();
        req0 = 1; req1 = 1; rw0 = 1; rw1 = 1; addr0 = 0; addr1 = 1;
        for (int c = 0; c < 12; c++) begin
            @(posedge CLK_); #1;
            if (ack0 || ack1) begin
                ack_cyc.push_back(c);
                ack_own.push_back(ack1 ? 1 : 0);
            end
        end
        clear_reqs();
        chk("rr_nacks", ack_cyc.size(), 4);
        for (int k = 0; k < ack_cyc.size() && k < 4; k++) begin
            chk($sformatf("rr_owner%0d", k), ack_own[k], k % 2);
            if (k > 0) chk($sformatf("rr_space%0d", k), ack_cyc[k] - ack_cyc[k-1], 3);
        end
        repeat (3) @(posedge CLK_);
        #1;

        // Read-after-write; an unrelated write must not touch rdata.
        do_txn(0, 1'b0, 1'b1, 8'h3C);
        do_txn(1, 1'b1, 1'b1, 8'h00);
        chk("raw_rdata", {24'd0, rdata}, 32'h3C);
        do_txn(0, 1'b0, 1'b0, 8'h77);
        chk("wr_keeps_rdata", {24'd0, rdata}, 32'h3C);
        do_txn(1, 1'b1, 1'b0, 8'h00);
        chk("rd_addr0", {24'd0, rdata}, 32'h77);

        // Reset in the middle of a write ACCESS.
        do_reset();
        keep = ram[1];
        req0 = 1; rw0 = 0; addr0 = 1; wdata0 = 8'h5A;
        @(posedge CLK_); #1;
        chk("abort_pre_rw", {31'd0, ram_r_w}, 0);
        #2 CLR = 1'b0;
        #1;
        chk("abort_rw", {31'd0, ram_r_w}, 1);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_gnt", {30'd0, gnt}, 0);
        clear_reqs();
        for (int c = 0; c < 2; c++) begin
            @(posedge CLK_); #1;
            chk("abort_noack", {30'd0, ack1, ack0}, 0);
        end
        chk("abort_mem", {24'd0, ram[1]}, {24'd0, keep});
        CLR = 1'b1;
        req0 = 1; req1 = 1; rw0 = 1; rw1 = 1;
        @(posedge CLK_); #1;
        chk("post_rst_gnt", {30'd0, gnt}, 32'h1);
        clear_reqs();
        repeat (3) @(posedge CLK_);
        #1;

        // req0 toggling while requester 1's write is in flight.
        do_reset();
        req1 = 1; rw1 = 0; addr1 = 0; wdata1 = 8'h11;
        @(posedge CLK_); #1;
        chk("tog_gnt_acc", {30'd0, gnt}, 32'h2);
        chk("tog_din", {24'd0, ram_din}, 32'h11);
        req0 = 1; rw0 = 0; addr0 = 1; wdata0 = 8'hEE;
        @(posedge CLK_); #1;
        chk("tog_ack", {30'd0, ack1, ack0}, 32'h2);
        chk("tog_gnt_done", {30'd0, gnt}, 32'h2);
        req0 = 0; req1 = 0;
        @(posedge CLK_); #1;
        chk("tog_idle", {31'd0, busy}, 0);
        chk("tog_mem", {24'd0, ram[0]}, 32'h11);
        do_txn(0, 1'b1, 1'b0, 8'h00);
        chk("tog_rdata", {24'd0, rdata}, 32'h11);

        // Randomized run against the timing model.
        do_txn(0, 1'b0, 1'b0, 8'h00);
        do_txn(0, 1'b0, 1'b1, 8'h00);
        do_reset();
        m_mem[0] = 0; m_mem[1] = 0; m_rdata = 0; m_ptr = 0; m_start = -10;
        m_own = 0; m_rw = 1; m_a = 0; m_d = 0;
        p[0] = 0; p[1] = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p[i] && $urandom_range(0, 2) != 0) begin
                    p[i] = 1;
                    q_rw[i] = 1'($urandom_range(0, 1));
                    q_a[i] = 1'($urandom_range(0, 1));
                    q_d[i] = 8'($urandom);
                end
            end
            req0 = p[0]; rw0 = q_rw[0]; addr0 = q_a[0]; wdata0 = q_d[0];
            req1 = p[1]; rw1 = q_rw[1]; addr1 = q_a[1]; wdata1 = q_d[1];
            if (cyc - m_start >= 3 && (p[0] || p[1])) begin
                m_own = (p[0] && p[1]) ? int'(m_ptr) : (p[0] ? 0 : 1);
                m_ptr = (m_own == 0);
                m_start = cyc;
                m_rw = q_rw[m_own]; m_a = q_a[m_own]; m_d = q_d[m_own];
            end
            ph = cyc - m_start;
            if (ph == 1 && !m_rw) m_mem[m_a] = m_d;
            if (ph == 2 && m_rw) m_rdata = m_mem[m_a];
            oh = (m_own == 0) ? 2'b01 : 2'b10;
            @(posedge CLK_); #1;
            chk("rnd_gnt", {30'd0, gnt}, (ph <= 1) ? {30'd0, oh} : 0);
            chk("rnd_ack", {30'd0, ack1, ack0}, (ph == 1) ? {30'd0, oh} : 0);
            chk("rnd_busy", {31'd0, busy}, (ph <= 1) ? 1 : 0);
            chk("rnd_rw", {31'd0, ram_r_w}, (ph == 0) ? {31'd0, m_rw} : 1);
            chk("rnd_rdata", {24'd0, rdata}, {24'd0, m_rdata});
            if (ph == 0) begin
                chk("rnd_addr", {31'd0, ram_addr}, {31'd0, m_a});
                if (!m_rw) chk("rnd_din", {24'd0, ram_din}, {24'd0, m_d});
            end
            if (ph == 1) p[m_own] = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
